// File: rtl/screen_pkg.sv
// Shared types and widths for the screen sequencer and its RGB scaler.
package screen_pkg;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_FADE_OUT  = 3'd1,
    ST_FADE_IN   = 3'd2,
    ST_GAME      = 3'd3,
    ST_OVER_HOLD = 3'd4
  } screen_state_t;

  localparam int LEVEL_W     = 5;
  localparam int LEVEL_MAX   = 16;
  localparam int LEVEL_SHIFT = 4;
  localparam int COLOR_W     = 8;
  localparam int CNT_W       = 10;

  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(LEVEL_MAX);

endpackage

// File: rtl/screen_sequencer_rgb_scaler.sv
// One colour channel: registered (c_in * level) >> 4, so level 16 is unity gain.
module rgb_scaler
  import screen_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] level,
  input  logic [COLOR_W-1:0] c_in,
  output logic [COLOR_W-1:0] c_out
);

  localparam int PROD_W = COLOR_W + LEVEL_W;

  logic [PROD_W-1:0] prod;

  // 255 * 16 needs 12 bits, so the shifted product always fits the channel
  assign prod = PROD_W'(c_in) * PROD_W'(level);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_out <= '0;
    end else begin
      c_out <= COLOR_W'(prod >> LEVEL_SHIFT);
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: menu -> game -> game-over -> menu with frame-synchronous fades.
// Define SCREEN_FADE_EN for the stepped fade; otherwise fades collapse to one cycle each.
//
// state        | meaning
// ST_MENU      | menu shown, waiting for start, playing=0
// ST_FADE_OUT  | brightness stepping down towards black
// ST_FADE_IN   | brightness stepping up after the screen swap
// ST_GAME      | map shown, waiting for game_over, playing=1
// ST_OVER_HOLD | game-over screen held at full brightness for HOLD_FRAMES
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES      = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               game_over,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               playing,
  output logic               game_reset,
  output logic               busy,
  output logic [LEVEL_W-1:0] level,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  if (FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 255) begin : g_bad_step
    $error("FADE_STEP_FRAMES must be 1..255");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 1023) begin : g_bad_hold
    $error("HOLD_FRAMES must be 1..1023");
  end

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_FRAMES);
`ifdef SCREEN_FADE_EN
  localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(FADE_STEP_FRAMES);
`endif

  screen_state_t     state;
  logic              target;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = frame_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_MENU;
      target     <= 1'b0;
      frame_cnt  <= '0;
      level      <= LEVEL_FULL;
      playing    <= 1'b0;
      busy       <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      game_reset <= 1'b0;
      unique case (state)
        ST_MENU: begin
          // a tick arriving with start is dropped, the fade counts from zero
          if (start) begin
            state     <= ST_FADE_OUT;
            target    <= 1'b1;
            frame_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_GAME: begin
          if (game_over) begin
            state     <= ST_OVER_HOLD;
            frame_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_OVER_HOLD: begin
          if (frame_tick) begin
            if (cnt_inc == HOLD_TC) begin
              state     <= ST_FADE_OUT;
              target    <= 1'b0;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        ST_FADE_OUT: begin
`ifdef SCREEN_FADE_EN
          if (level == '0) begin
            state      <= ST_FADE_IN;
            playing    <= target;
            game_reset <= target;
            frame_cnt  <= '0;
          end else if (frame_tick) begin
            if (cnt_inc == STEP_TC) begin
              level     <= level - LEVEL_W'(1);
              frame_cnt <= '0;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
`else
          state      <= ST_FADE_IN;
          playing    <= target;
          game_reset <= target;
`endif
        end
        ST_FADE_IN: begin
`ifdef SCREEN_FADE_EN
          if (frame_tick) begin
            if (cnt_inc == STEP_TC) begin
              level     <= level + LEVEL_W'(1);
              frame_cnt <= '0;
              if (level == LEVEL_FULL - LEVEL_W'(1)) begin
                state <= target ? ST_GAME : ST_MENU;
                busy  <= 1'b0;
              end
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
`else
          state <= target ? ST_GAME : ST_MENU;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= ST_MENU;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  rgb_scaler u_scale_r (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (level),
    .c_in   (r_in),
    .c_out  (r)
  );

  rgb_scaler u_scale_g (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (level),
    .c_in   (g_in),
    .c_out  (g)
  );

  rgb_scaler u_scale_b (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (level),
    .c_in   (b_in),
    .c_out  (b)
  );

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer; RGB expectations go through a one-deep scoreboard queue.
module tb_screen_sequencer;

  localparam int STEP = 2;
  localparam int HOLD = 120;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] r_in = 8'hAA;
  logic [7:0] g_in = 8'h55;
  logic [7:0] b_in = 8'hFF;
  logic       playing, game_reset, busy;
  logic [4:0] level;
  logic [7:0] r, g, b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_level = 16;
  int tcnt = 0;
  logic [23:0] exp_q[$];

  screen_sequencer #(
    .FADE_STEP_FRAMES(STEP),
    .HOLD_FRAMES     (HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .start     (start),
    .game_over (game_over),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .playing   (playing),
    .game_reset(game_reset),
    .busy      (busy),
    .level     (level),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] scale(input logic [7:0] c, input int lv);
    return 8'((int'(c) * lv) >> 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [23:0] e;
    exp_q.push_back(reset_n ? {scale(r_in, exp_level), scale(g_in, exp_level), scale(b_in, exp_level)}
                            : 24'h0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rgb", {r, g, b}, e);
  endtask

  task automatic ctrl(input string tag, input logic p, input logic gr, input logic bz);
    check({tag, ".playing"}, playing, p);
    check({tag, ".game_reset"}, game_reset, gr);
    check({tag, ".busy"}, busy, bz);
    check({tag, ".level"}, level, exp_level);
  endtask

  // one frame = tick cycle + idle cycle; bench tracks brightness from the tick count
  task automatic frames_fade(input int n, input int dir);
    tcnt = 0;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      tcnt++;
      if (tcnt == STEP) begin
        tcnt = 0;
        exp_level += dir;
      end
      check("fade.level", level, exp_level);
      cycle();
    end
  endtask

  task automatic frames_hold(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      check("hold.playing", playing, 1'b1);
      check("hold.busy", busy, 1'b1);
      cycle();
    end
  endtask

  initial begin
    // reset state
    cycle();
    cycle();
    ctrl("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // pass-through at full brightness, one cycle latency
    cycle();
    r_in = 8'h00; g_in = 8'h01; b_in = 8'h80;
    cycle();
    r_in = 8'hFF; g_in = 8'hFE; b_in = 8'h7F;
    cycle();
    ctrl("menu", 1'b0, 1'b0, 1'b0);

    // game_over in MENU is ignored
    game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    ctrl("menu_go", 1'b0, 1'b0, 1'b0);
    cycle();
    ctrl("menu_go2", 1'b0, 1'b0, 1'b0);

    // start coincident with frame_tick; the tick must not count
    r_in = 8'hFF; g_in = 8'h80; b_in = 8'h01;
    start = 1'b1;
    frame_tick = 1'b1;
    cycle();
    start = 1'b0;
    frame_tick = 1'b0;
    ctrl("start", 1'b0, 1'b0, 1'b1);
`ifdef SCREEN_FADE_EN
    frames_fade(10, -1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    frames_fade(22, -1);
    ctrl("black_swap", 1'b1, 1'b1, 1'b1);
    cycle();
    ctrl("after_swap", 1'b1, 1'b0, 1'b1);
    frames_fade(32, 1);
    ctrl("game", 1'b1, 1'b0, 1'b0);
`else
    start = 1'b1;
    cycle();
    start = 1'b0;
    ctrl("swap", 1'b1, 1'b1, 1'b1);
    cycle();
    ctrl("game", 1'b1, 1'b0, 1'b0);
`endif
    cycle();
    ctrl("game2", 1'b1, 1'b0, 1'b0);

    // start in GAME is ignored
    start = 1'b1;
    cycle();
    start = 1'b0;
    ctrl("game_start", 1'b1, 1'b0, 1'b0);

    // game_over coincident with tick, then HOLD-1 more ticks keep the hold
    game_over = 1'b1;
    frame_tick = 1'b1;
    cycle();
    game_over = 1'b0;
    frame_tick = 1'b0;
    ctrl("over", 1'b1, 1'b0, 1'b1);
    cycle();
    start = 1'b1;
    game_over = 1'b1;
    cycle();
    start = 1'b0;
    game_over = 1'b0;
    frames_hold(HOLD - 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      ctrl("hold_edge", 1'b1, 1'b0, 1'b1);
    end
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    ctrl("hold_done", 1'b1, 1'b0, 1'b1);
`ifdef SCREEN_FADE_EN
    cycle();
    frames_fade(32, -1);
    ctrl("menu_swap", 1'b0, 1'b0, 1'b1);
    frames_fade(32, 1);
    ctrl("menu_back", 1'b0, 1'b0, 1'b0);
`else
    cycle();
    ctrl("menu_swap", 1'b0, 1'b0, 1'b1);
    cycle();
    ctrl("menu_back", 1'b0, 1'b0, 1'b0);
`endif
    // start pulsed during the hold was not queued
    cycle();
    ctrl("no_queue", 1'b0, 1'b0, 1'b0);

    // reset in the middle of a transition
    r_in = 8'h3C; g_in = 8'hC3; b_in = 8'h99;
    start = 1'b1;
    cycle();
    start = 1'b0;
`ifdef SCREEN_FADE_EN
    frames_fade(32, -1);
    frames_fade(10, 1);
    check("mid_fade.level", level, 5);
`else
    cycle();
    cycle();
    game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    frames_hold(10);
`endif
    reset_n = 1'b0;
    cycle();
    exp_level = 16;
    ctrl("mid_reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cycle();
    ctrl("post_reset", 1'b0, 1'b0, 1'b0);
`ifndef SCREEN_FADE_EN
    start = 1'b1;
    cycle();
    start = 1'b0;
    ctrl("quick1", 1'b0, 1'b0, 1'b1);
    cycle();
    ctrl("quick2", 1'b1, 1'b1, 1'b1);
    cycle();
    ctrl("quick3", 1'b1, 1'b0, 1'b0);
`endif
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
